// File: rtl/shared_result_collector.sv
// Two-lane result collector: per-lane FIFOs with stall back to the producer,
// round-robin merge into one registered, lane-tagged output stream with flush echo.

module shared_result_collector_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

module shared_result_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_flush_1,
  output logic              out_stall_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_flush_2,
  output logic              out_stall_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lane,
  output logic [1:0]        out_flush,
  input  logic              in_stall
);
  logic              push_1, push_2, pop_1, pop_2;
  logic              empty_1, empty_2;
  logic [DATA_W-1:0] head_1, head_2;
  logic              cand_1, cand_2, sel, load;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              lane_q, lane_d;
  logic [1:0]        flush_q, flush_d;
  logic              rr_last_q, rr_last_d;

  assign push_1 = in_valid_1 && !out_stall_1 && !in_flush_1;
  assign push_2 = in_valid_2 && !out_stall_2 && !in_flush_2;
  assign cand_1 = !empty_1 && !in_flush_1;
  assign cand_2 = !empty_2 && !in_flush_2;
  assign load   = !(valid_q && in_stall);

  // sel: 0 = lane 1, 1 = lane 2; on contention the lane not served last wins.
  always_comb begin
    sel = 1'b0;
    if (cand_1 && cand_2) sel = !rr_last_q;
    else if (cand_2)      sel = 1'b1;
  end

  assign pop_1 = load && cand_1 && !sel;
  assign pop_2 = load && cand_2 && sel;

  shared_result_collector_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_1),
    .pop_i   (pop_1),
    .flush_i (in_flush_1),
    .wdata_i (in_data_1),
    .head_o  (head_1),
    .empty_o (empty_1),
    .full_o  (out_stall_1)
  );

  shared_result_collector_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_2),
    .pop_i   (pop_2),
    .flush_i (in_flush_2),
    .wdata_i (in_data_2),
    .head_o  (head_2),
    .empty_o (empty_2),
    .full_o  (out_stall_2)
  );

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    lane_d    = lane_q;
    rr_last_d = rr_last_q;
    flush_d   = {in_flush_2, in_flush_1};
    if (load) begin
      if (cand_1 || cand_2) begin
        valid_d   = 1'b1;
        data_d    = sel ? head_2 : head_1;
        lane_d    = sel;
        rr_last_d = sel;
      end else begin
        valid_d = 1'b0;
      end
    end else if ((in_flush_1 && !lane_q) || (in_flush_2 && lane_q)) begin
      // A flush of the held beat's lane overrides downstream stall.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      lane_q    <= 1'b0;
      flush_q   <= 2'b00;
      rr_last_q <= 1'b1;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      lane_q    <= lane_d;
      flush_q   <= flush_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_lane  = lane_q;
  assign out_flush = flush_q;
endmodule

// File: tb/tb_shared_result_collector.sv
// Scoreboard bench for shared_result_collector: directed vectors queue expected
// beats, a negedge monitor pops and compares every beat the DUT hands downstream.

module tb_shared_result_collector;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid_1 = 1'b0, in_flush_1 = 1'b0;
  logic [DW-1:0] in_data_1 = '0;
  logic          in_valid_2 = 1'b0, in_flush_2 = 1'b0;
  logic [DW-1:0] in_data_2 = '0;
  logic          in_stall = 1'b0;
  logic          out_stall_1, out_stall_2, out_valid, out_lane;
  logic [DW-1:0] out_data;
  logic [1:0]    out_flush;

  typedef struct packed {
    logic          lane;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    done5 = 1'b0;

  always #5 clk = ~clk;

  shared_result_collector #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_1  (in_valid_1),
    .in_data_1   (in_data_1),
    .in_flush_1  (in_flush_1),
    .out_stall_1 (out_stall_1),
    .in_valid_2  (in_valid_2),
    .in_data_2   (in_data_2),
    .in_flush_2  (in_flush_2),
    .out_stall_2 (out_stall_2),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_lane    (out_lane),
    .out_flush   (out_flush),
    .in_stall    (in_stall)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // A beat with out_valid & !in_stall at the negedge is taken at the next rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && !in_stall) begin
      beat_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_beat: actual lane %0d data %0h required no beat", out_lane, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_lane, out_data} !== e) begin
          n_err++;
          $display("FAIL out_beat: actual lane %0d data %0h required lane %0d data %0h",
                   out_lane, out_data, e.lane, e.data);
        end
      end
    end
  end

  function automatic beat_t bt(input logic ln, input logic [DW-1:0] d);
    bt.lane = ln;
    bt.data = d;
  endfunction

  task automatic send(input int ln, input logic [DW-1:0] d);
    int k;
    logic stl;
    @(negedge clk);
    if (ln == 1) begin in_valid_1 = 1'b1; in_data_1 = d; end
    else         begin in_valid_2 = 1'b1; in_data_2 = d; end
    for (k = 0; k < 200; k++) begin
      stl = (ln == 1) ? out_stall_1 : out_stall_2;
      if (!stl) break;
      @(negedge clk);
    end
    if (k == 200) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: lane %0d still stalled, required accept", ln);
    end
    @(posedge clk);
    #1;
    if (ln == 1) in_valid_1 = 1'b0;
    else         in_valid_2 = 1'b0;
  endtask

  task automatic set_stall(input logic v);
    @(posedge clk);
    #1 in_stall = v;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_flush_1 = 1'b0; in_flush_2 = 1'b0;
    in_stall = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic single_beat(input logic [DW-1:0] d);
    @(negedge clk);
    in_valid_1 = 1'b1;
    in_data_1  = d;
    exp_q.push_back(bt(1'b0, d));
    @(posedge clk);
    #1 in_valid_1 = 1'b0;
    chk("single_valid_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    chk("single_valid_edge2", out_valid, 1);
    chk("single_data", out_data, d);
    chk("single_lane", out_lane, 0);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_flush", out_flush, 0);
    chk("rst_stall_1", out_stall_1, 0);
    chk("rst_stall_2", out_stall_2, 0);

    single_beat(32'hA5A5_0001);

    // Backpressure fill: beat 1 in the output register, 2 and 3 fill the lane FIFO.
    for (int i = 1; i <= 4; i++) exp_q.push_back(bt(1'b0, DW'(i)));
    set_stall(1'b1);
    send(1, 32'd1);
    send(1, 32'd2);
    chk("fill_stall_after2", out_stall_1, 0);
    send(1, 32'd3);
    chk("fill_stall_after3", out_stall_1, 1);
    fork
      send(1, 32'd4);
      begin repeat (3) @(posedge clk); #1 in_stall = 1'b0; end
    join
    wait_drain();
    chk("fill_stall_drained", out_stall_1, 0);

    // Round-robin merge from a fresh rr state.
    do_reset();
    exp_q.push_back(bt(1'b0, 32'd10));
    exp_q.push_back(bt(1'b1, 32'd20));
    exp_q.push_back(bt(1'b0, 32'd11));
    exp_q.push_back(bt(1'b1, 32'd21));
    exp_q.push_back(bt(1'b0, 32'd12));
    exp_q.push_back(bt(1'b1, 32'd22));
    set_stall(1'b1);
    fork
      begin send(1, 32'd10); send(1, 32'd11); send(1, 32'd12); end
      begin send(2, 32'd20); send(2, 32'd21); send(2, 32'd22); end
      begin repeat (4) @(posedge clk); #1 in_stall = 1'b0; end
    join
    wait_drain();

    // Flush lane 2 while its beat is held under stall; lane 1 then loads.
    do_reset();
    set_stall(1'b1);
    send(2, 32'd30);
    send(2, 32'd31);
    send(2, 32'd32);
    send(1, 32'd40);
    chk("flush_pre_valid", out_valid, 1);
    chk("flush_pre_lane", out_lane, 1);
    chk("flush_pre_data", out_data, 32'd30);
    chk("flush_pre_stall_2", out_stall_2, 1);
    @(negedge clk);
    in_flush_2 = 1'b1;
    @(posedge clk);
    #1 in_flush_2 = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_echo", out_flush, 2'b10);
    chk("flush_stall_2", out_stall_2, 0);
    @(posedge clk);
    #1;
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_data", out_data, 32'd40);
    chk("flush_next_lane", out_lane, 0);
    chk("flush_next_echo", out_flush, 2'b00);
    exp_q.push_back(bt(1'b0, 32'd40));
    exp_q.push_back(bt(1'b1, 32'd50));
    set_stall(1'b0);
    send(2, 32'd50);
    wait_drain();

    // Pointer wrap with random downstream stall.
    for (int i = 0; i < 4 * DEPTH; i++) exp_q.push_back(bt(1'b0, DW'(100 + i)));
    fork
      begin
        for (int i = 0; i < 4 * DEPTH; i++) send(1, DW'(100 + i));
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          @(posedge clk);
          #1 in_stall = 1'($urandom_range(0, 1));
        end
      end
    join
    set_stall(1'b0);
    wait_drain();

    // Asynchronous reset with both FIFOs partly full.
    set_stall(1'b1);
    send(1, 32'd60);
    send(1, 32'd61);
    send(2, 32'd70);
    chk("rst_mid_pre_valid", out_valid, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_lane", out_lane, 0);
    chk("rst_mid_flush", out_flush, 0);
    chk("rst_mid_stall_1", out_stall_1, 0);
    chk("rst_mid_stall_2", out_stall_2, 0);
    exp_q.delete();
    in_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    single_beat(32'hA5A5_0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
